i2c_txn_sequencer: RTL and testbench

Transaction sequencer and arbiter in front of the I2C master. It shares the master between NREQ on-chip requesters (sensor poller, config loader) using round-robin arbitration, and drives the master's en/Start/repeat_start/Stop controls through a fixed phase sequence. It latches read data and returns one response per granted request, with an error flag on NACK or watchdog timeout.

---
 rtl/i2c_txn_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin arbiter and phase sequencer in front of the
// I2C master. Each granted request runs SETUP -> WR -> (RD) -> STOP -> RESP
// and returns one response carrying the read byte and an error flag
// (slave NACK or a phase that outlives the TIMEOUT watchdog).
module i2c_txn_sequencer #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [7*NREQ-1:0]    req_addr,
   input  logic [8*NREQ-1:0]    req_reg,
   input  logic [NREQ-1:0]      req_rnw,
   output logic [NREQ-1:0]      grant,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_id,
   output logic [7:0]           rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [6:0]           m_address,
   output logic [7:0]           m_register,
   output logic                 m_mode,
   output logic                 m_en,
   output logic                 m_start,
   output logic                 m_repeat_start,
   output logic                 m_stop,
   input  logic                 m_done,
   input  logic                 m_ack,
   input  logic [7:0]           m_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // Counter value on the cycle whose closing edge makes it reach TIMEOUT.
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_WR    = 3'd2,
      S_RD    = 3'd3,
      S_STOP  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t          r_state;
   logic [1:0]      r_rr;
   logic [1:0]      r_id;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_data;
   logic            r_err;

   logic            w_any;
   logic [NREQ-1:0] w_hi_req;
   logic [NREQ-1:0] w_sel_req;
   logic [1:0]      w_win;
   logic [NREQ-1:0] w_onehot;
   logic [6:0]      w_addr;
   logic [7:0]      w_reg;
   logic            w_rnw;
   logic            w_tmo;

   // Round-robin pick: lowest requester at/after the pointer, else lowest overall.
   always_comb begin
      w_any     = |req;
      w_hi_req  = '0;
      w_win     = 2'd0;
      w_onehot  = '0;
      w_addr    = 7'h00;
      w_reg     = 8'h00;
      w_rnw     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_hi_req[i] = req[i] & (2'(i) >= r_rr);
      end
      w_sel_req = (|w_hi_req) ? w_hi_req : req;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_win = w_sel_req[i] ? 2'(i) : w_win;
      end
      for (int i = 0; i < NREQ; i++) begin
         w_onehot[i] = w_any & (2'(i) == w_win);
         w_addr      = w_addr | ({7{w_onehot[i]}} & req_addr[7*i +: 7]);
         w_reg       = w_reg  | ({8{w_onehot[i]}} & req_reg[8*i +: 8]);
         w_rnw       = w_rnw  | (w_onehot[i] & req_rnw[i]);
      end
      w_tmo = (r_cnt == TO_LAST);
   end

   // Transaction FSM: phase strobes, watchdog, response and arbitration pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_rr           <= 2'd0;
         r_id           <= 2'd0;
         r_cnt          <= '0;
         r_data         <= 8'h00;
         r_err          <= 1'b0;
         grant          <= '0;
         rsp_valid      <= 1'b0;
         rsp_id         <= 2'd0;
         rsp_data       <= 8'h00;
         rsp_err        <= 1'b0;
         busy           <= 1'b0;
         m_address      <= 7'h00;
         m_register     <= 8'h00;
         m_mode         <= 1'b0;
         m_en           <= 1'b0;
         m_start        <= 1'b0;
         m_repeat_start <= 1'b0;
         m_stop         <= 1'b0;
      end else begin
         grant     <= '0;
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               busy           <= w_any;
               m_en           <= w_any;
               m_start        <= 1'b0;
               m_repeat_start <= 1'b0;
               m_stop         <= 1'b0;
               if (w_any) begin
                  grant      <= w_onehot;
                  m_address  <= w_addr;
                  m_register <= w_reg;
                  m_mode     <= w_rnw;
                  r_id       <= w_win;
                  r_data     <= 8'h00;
                  r_err      <= 1'b0;
                  r_state    <= S_SETUP;
               end else begin
                  r_state    <= S_IDLE;
               end
            end
            S_SETUP: begin
               r_cnt   <= '0;
               m_start <= 1'b1;
               r_state <= S_WR;
            end
            S_WR: begin
               if (m_done) begin
                  m_start <= 1'b0;
                  r_cnt   <= '0;
                  if (!m_ack) begin
                     r_err   <= 1'b1;
                     m_stop  <= 1'b1;
                     r_state <= S_STOP;
                  end else if (m_mode) begin
                     m_repeat_start <= 1'b1;
                     r_state        <= S_RD;
                  end else begin
                     m_stop  <= 1'b1;
                     r_state <= S_STOP;
                  end
               end else if (w_tmo) begin
                  m_start <= 1'b0;
                  m_stop  <= 1'b1;
                  r_err   <= 1'b1;
                  r_data  <= 8'h00;
                  r_cnt   <= '0;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RD: begin
               if (m_done) begin
                  r_data         <= m_rdata;
                  r_err          <= r_err | ~m_ack;
                  m_repeat_start <= 1'b0;
                  m_stop         <= 1'b1;
                  r_cnt          <= '0;
                  r_state        <= S_STOP;
               end else if (w_tmo) begin
                  r_err          <= 1'b1;
                  r_data         <= 8'h00;
                  m_repeat_start <= 1'b0;
                  m_stop         <= 1'b1;
                  r_cnt          <= '0;
                  r_state        <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               // The ACK seen with the STOP completion is deliberately ignored.
               if (m_done) begin
                  m_stop  <= 1'b0;
                  m_en    <= 1'b0;
                  r_state <= S_RESP;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  m_stop  <= 1'b0;
                  m_en    <= 1'b0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               rsp_valid <= 1'b1;
               rsp_id    <= r_id;
               rsp_data  <= r_err ? 8'h00 : r_data;
               rsp_err   <= r_err;
               r_rr      <= (r_id == 2'(NREQ - 1)) ? 2'd0 : r_id + 2'd1;
               r_state   <= S_IDLE;
            end
            default: begin
               m_en           <= 1'b0;
               m_start        <= 1'b0;
               m_repeat_start <= 1'b0;
               m_stop         <= 1'b0;
               busy           <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: scoreboard bench with a small I2C master model that
// answers each phase three cycles after its strobe appears.
module tb_i2c_txn_sequencer;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       err;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [7*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_reg;
   logic [NREQ-1:0]   req_rnw;
   logic [NREQ-1:0]   grant;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [7:0]        rsp_data;
   logic              rsp_err;
   logic              busy;
   logic [6:0]        m_address;
   logic [7:0]        m_register;
   logic              m_mode, m_en, m_start, m_repeat_start, m_stop;
   logic              m_done  = 1'b0;
   logic              m_ack   = 1'b0;
   logic [7:0]        m_rdata = 8'h00;

   rsp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // master model configuration
   logic       mm_ack_wr    = 1'b1;
   logic       mm_silent_rd = 1'b0;
   logic [7:0] mm_rdata     = 8'h00;
   logic [2:0] mm_last      = 3'b000;
   int         mm_cnt       = 0;
   logic       mm_fired     = 1'b0;

   // monitor totals
   int   mon_cyc = 0, mon_rs_cyc = 0, mon_overlap = 0, mon_s2p = 0;
   int   mon_stop_done = 0, mon_lat = -1, mon_rsp_cnt = 0;
   logic mon_prev_start = 1'b0;

   i2c_txn_sequencer #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_reg(req_reg),
      .req_rnw(req_rnw), .grant(grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_address(m_address),
      .m_register(m_register), .m_mode(m_mode), .m_en(m_en), .m_start(m_start),
      .m_repeat_start(m_repeat_start), .m_stop(m_stop), .m_done(m_done),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Master model: one m_done pulse on the third cycle of each new phase.
   always @(negedge clk) begin : master_model
      logic [2:0] ph;
      ph     = {m_start, m_repeat_start, m_stop};
      m_done = 1'b0;
      m_ack  = 1'b0;
      if (reset || !m_en || ph == 3'b000) begin
         mm_last  = 3'b000;
         mm_cnt   = 0;
         mm_fired = 1'b0;
      end else begin
         if (ph != mm_last) begin
            mm_last  = ph;
            mm_cnt   = 1;
            mm_fired = 1'b0;
         end else begin
            mm_cnt++;
         end
         if (!mm_fired && mm_cnt == 3 && !(ph == 3'b010 && mm_silent_rd)) begin
            m_done   = 1'b1;
            m_ack    = (ph == 3'b100) ? mm_ack_wr : 1'b1;
            m_rdata  = mm_rdata;
            mm_fired = 1'b1;
         end
      end
   end

   // Monitor: strobe occupancy and STOP-done to rsp_valid latency.
   always @(negedge clk) begin
      #1;
      mon_cyc++;
      if (m_repeat_start) mon_rs_cyc++;
      if ((int'(m_start) + int'(m_repeat_start) + int'(m_stop)) > 1) mon_overlap++;
      if (mon_prev_start && m_stop) mon_s2p++;
      mon_prev_start = m_start;
      if (m_done && m_stop) mon_stop_done = mon_cyc;
      if (rsp_valid) begin
         mon_rsp_cnt++;
         mon_lat = mon_cyc - mon_stop_done;
      end
   end

   task automatic wait_grant(output int n, output logic [NREQ-1:0] g);
      n = 0;
      g = '0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (grant != '0) begin
            n = k;
            g = grant;
            break;
         end
      end
   endtask

   task automatic wait_rsp(output logic ok, output rsp_t got, output logic b, output logic en);
      ok  = 1'b0;
      got = '0;
      b   = 1'b0;
      en  = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok  = 1'b1;
            got = {rsp_id, rsp_data, rsp_err};
            b   = busy;
            en  = m_en;
            break;
         end
      end
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; req_addr = '0; req_reg = '0; req_rnw = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({grant, rsp_valid, busy, m_en, m_start, m_repeat_start, m_stop} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0", {grant, rsp_valid, busy, m_en, m_start, m_repeat_start, m_stop});
      end
      n_checks++;
      if ({m_address, m_register, m_mode, rsp_id, rsp_data, rsp_err} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {m_address, m_register, m_mode, rsp_id, rsp_data, rsp_err});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, m_en, grant} !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b required 0", {busy, m_en, grant});
      end
   endtask

   task automatic test_single_read();
      int n; logic [NREQ-1:0] g; logic ok, b, en; rsp_t got, exp; int rs0, ov0;
      mm_ack_wr = 1'b1; mm_silent_rd = 1'b0; mm_rdata = 8'hF0;
      rs0 = mon_rs_cyc; ov0 = mon_overlap;
      req_addr[6:0] = 7'h70; req_reg[7:0] = 8'hB2; req_rnw[0] = 1'b1; req[0] = 1'b1;
      sb_q.push_back('{id: 2'd0, data: 8'hF0, err: 1'b0});
      wait_grant(n, g);
      req[0] = 1'b0;
      n_checks++;
      if (g !== 2'b01 || n !== 1) begin
         n_fail++; $display("FAIL rd_grant: got %b after %0d cycles required 01 after 1", g, n);
      end
      n_checks++;
      if ({m_address, m_register, m_mode, busy, m_en} !== {7'h70, 8'hB2, 1'b1, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL rd_latch: got addr %h reg %h mode %b busy %b en %b required 70 b2 1 1 1", m_address, m_register, m_mode, busy, m_en);
      end
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
         n_fail++; $display("FAIL rd_rsp: valid %b id %0d data %h err %b required id %0d data %h err %b", ok, got.id, got.data, got.err, exp.id, exp.data, exp.err);
      end
      n_checks++;
      if (mon_rs_cyc - rs0 !== 3 || mon_overlap !== ov0) begin
         n_fail++; $display("FAIL rd_repeat_start: got %0d rs cycles %0d overlaps required 3 and 0", mon_rs_cyc - rs0, mon_overlap - ov0);
      end
      n_checks++;
      if (mon_lat !== 2 || b !== 1'b1 || en !== 1'b0) begin
         n_fail++; $display("FAIL rd_resp_timing: got lat %0d busy %b en %b required 2 1 0", mon_lat, b, en);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid, rsp_data} !== {1'b0, 1'b0, 8'hF0}) begin
         n_fail++; $display("FAIL rd_after: got busy %b valid %b data %h required 0 0 f0", busy, rsp_valid, rsp_data);
      end
   endtask

   task automatic test_write();
      int n; logic [NREQ-1:0] g; logic ok, b, en; rsp_t got, exp; int rs0, sp0;
      rs0 = mon_rs_cyc; sp0 = mon_s2p;
      req_addr[13:7] = 7'h38; req_reg[15:8] = 8'h5A; req_rnw[1] = 1'b0; req[1] = 1'b1;
      sb_q.push_back('{id: 2'd1, data: 8'h00, err: 1'b0});
      wait_grant(n, g);
      req[1] = 1'b0;
      n_checks++;
      if (g !== 2'b10 || {m_address, m_register, m_mode} !== {7'h38, 8'h5A, 1'b0}) begin
         n_fail++; $display("FAIL wr_grant: got %b addr %h reg %h mode %b required 10 38 5a 0", g, m_address, m_register, m_mode);
      end
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
         n_fail++; $display("FAIL wr_rsp: valid %b id %0d data %h err %b required id %0d data %h err %b", ok, got.id, got.data, got.err, exp.id, exp.data, exp.err);
      end
      n_checks++;
      if (mon_rs_cyc - rs0 !== 0 || mon_s2p - sp0 !== 1) begin
         n_fail++; $display("FAIL wr_phases: got %0d rs cycles %0d start->stop required 0 and 1", mon_rs_cyc - rs0, mon_s2p - sp0);
      end
   endtask

   task automatic test_round_robin();
      int n; logic [NREQ-1:0] g, eg; logic ok, b, en; rsp_t got, exp;
      mm_rdata = 8'hC3;
      req_addr = {7'h33, 7'h11}; req_reg = {8'h44, 8'h22}; req_rnw = 2'b01;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) sb_q.push_back('{id: 2'd0, data: 8'hC3, err: 1'b0});
         else            sb_q.push_back('{id: 2'd1, data: 8'h00, err: 1'b0});
      end
      for (int k = 0; k < 4; k++) begin
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_grant(n, g);
         if (k == 3) req = 2'b00;
         n_checks++;
         if (g !== eg || n !== 1) begin
            n_fail++; $display("FAIL rr_grant%0d: got %b after %0d cycles required %b after 1", k, g, n, eg);
         end
         wait_rsp(ok, got, b, en);
         exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
         n_checks++;
         if (!ok || got !== exp || en !== 1'b0) begin
            n_fail++; $display("FAIL rr_rsp%0d: valid %b id %0d data %h err %b en %b required id %0d data %h err %b en 0", k, ok, got.id, got.data, got.err, en, exp.id, exp.data, exp.err);
         end
      end
   endtask

   task automatic test_nack();
      int n; logic [NREQ-1:0] g; logic ok, b, en; rsp_t got, exp; int rs0;
      mm_ack_wr = 1'b0; mm_rdata = 8'hA5; rs0 = mon_rs_cyc;
      req_rnw[0] = 1'b1; req[0] = 1'b1;
      sb_q.push_back('{id: 2'd0, data: 8'h00, err: 1'b1});
      wait_grant(n, g);
      req[0] = 1'b0;
      n_checks++;
      if (g !== 2'b01) begin
         n_fail++; $display("FAIL nack_grant: got %b required 01", g);
      end
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp || mon_rs_cyc - rs0 !== 0) begin
         n_fail++; $display("FAIL nack_rsp: valid %b id %0d data %h err %b rs %0d required id %0d data %h err %b rs 0", ok, got.id, got.data, got.err, mon_rs_cyc - rs0, exp.id, exp.data, exp.err);
      end
      mm_ack_wr = 1'b1;
   endtask

   task automatic test_timeout();
      int n; logic [NREQ-1:0] g; logic ok, b, en; rsp_t got, exp; int rs0;
      mm_silent_rd = 1'b1; mm_rdata = 8'h77; rs0 = mon_rs_cyc;
      req[0] = 1'b1;
      sb_q.push_back('{id: 2'd0, data: 8'h00, err: 1'b1});
      wait_grant(n, g);
      req[0] = 1'b0;
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
         n_fail++; $display("FAIL tmo_rsp: valid %b id %0d data %h err %b required id %0d data %h err %b", ok, got.id, got.data, got.err, exp.id, exp.data, exp.err);
      end
      n_checks++;
      if (mon_rs_cyc - rs0 !== TIMEOUT || mon_lat !== 2) begin
         n_fail++; $display("FAIL tmo_rd_len: got %0d rd cycles lat %0d required %0d and 2", mon_rs_cyc - rs0, mon_lat, TIMEOUT);
      end
      mm_silent_rd = 1'b0;
   endtask

   task automatic test_reset_mid_rd();
      int n, rc0; logic [NREQ-1:0] g; logic ok, b, en, seen; rsp_t got, exp;
      req_rnw = 2'b11; req[1] = 1'b1;
      wait_grant(n, g);
      req[1] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_repeat_start) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL rst_reach_rd: got no RD phase required RD phase");
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({m_en, m_repeat_start, busy, grant, rsp_valid} !== 6'd0) begin
         n_fail++; $display("FAIL rst_abort: got %b required 0", {m_en, m_repeat_start, busy, grant, rsp_valid});
      end
      reset = 1'b0; rc0 = mon_rsp_cnt;
      repeat (20) @(negedge clk);
      n_checks++;
      if (mon_rsp_cnt !== rc0) begin
         n_fail++; $display("FAIL rst_no_rsp: got %0d responses required 0", mon_rsp_cnt - rc0);
      end
      mm_rdata = 8'h5E; req_rnw = 2'b01; req = 2'b11;
      sb_q.push_back('{id: 2'd0, data: 8'h5E, err: 1'b0});
      wait_grant(n, g);
      req = 2'b00;
      n_checks++;
      if (g !== 2'b01) begin
         n_fail++; $display("FAIL rst_ptr_grant: got %b required 01", g);
      end
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
         n_fail++; $display("FAIL rst_rsp: valid %b id %0d data %h err %b required id %0d data %h err %b", ok, got.id, got.data, got.err, exp.id, exp.data, exp.err);
      end
      req[1] = 1'b1;
      sb_q.push_back('{id: 2'd1, data: 8'h00, err: 1'b0});
      wait_grant(n, g);
      req = 2'b00;
      wait_rsp(ok, got, b, en);
      exp = '1; if (sb_q.size() > 0) exp = sb_q.pop_front();
      n_checks++;
      if (g !== 2'b10 || !ok || got !== exp) begin
         n_fail++; $display("FAIL rst_req1: grant %b valid %b id %0d data %h err %b required 10 id %0d data %h err %b", g, ok, got.id, got.data, got.err, exp.id, exp.data, exp.err);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_round_robin();
      test_nack();
      test_timeout();
      test_reset_mid_rd();
      n_checks++;
      if (sb_q.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
